// File: rtl/rom_arbiter_if.sv
// Client-side bus of rom_arbiter: two request/address pairs in, grants, read strobes and data out.
// The slave modport is the arbiter's view; the master modport is the clients' view.
interface rom_arbiter_if #(
   parameter int Width = 8,
   parameter int Depth = 5
);
   logic             req0_i;
   logic             req1_i;
   logic [Depth-1:0] addr0_i;
   logic [Depth-1:0] addr1_i;
   logic             gnt0_o;
   logic             gnt1_o;
   logic             rvalid0_o;
   logic             rvalid1_o;
   logic [Width-1:0] rdata_o;
   logic             busy_o;

   modport slave (
      input  req0_i, req1_i, addr0_i, addr1_i,
      output gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, rdata_o, busy_o
   );

   modport master (
      output req0_i, req1_i, addr0_i, addr1_i,
      input  gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, rdata_o, busy_o
   );
endinterface

// File: rtl/rom_arbiter.sv
// Two-client round-robin arbiter that sequences chip-select, output-enable and address
// for an asynchronous-read ROM, returning each word with a one-cycle valid strobe.
module rom_arbiter #(
   parameter int Width = 8,
   parameter int Depth = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   rom_arbiter_if.slave     bus,
   output logic             rom_cs_no,
   output logic             rom_oe_o,
   output logic [Depth-1:0] rom_addr_o,
   input  logic [Width-1:0] rom_data_i
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SETUP = 2'd1;
   localparam logic [1:0] ST_READ  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic             owner_q, owner_d;   // 0: client 0 owns the ROM, 1: client 1
   logic             ptr_q,   ptr_d;     // client favoured when both request
   logic [Depth-1:0] addr_q,  addr_d;
   logic [Width-1:0] rdata_q, rdata_d;
   logic             winner;

   // Both requesting: the pointer decides; otherwise whichever one is asking.
   assign winner = (bus.req0_i && bus.req1_i) ? ptr_q : bus.req1_i;

   always_comb begin
      // NOTE: every _d gets its hold value first, so no path through the case leaves
      // a signal unassigned and no latch is inferred.
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      addr_d  = addr_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req0_i || bus.req1_i) begin
               owner_d = winner;
               addr_d  = winner ? bus.addr1_i : bus.addr0_i;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: state_d = ST_READ;
         ST_READ: begin
            rdata_d = rom_data_i;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            ptr_d   = ~owner_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values,
      // independent of statement order.
      if (rst_i) begin
         state_q <= ST_IDLE;
         owner_q <= 1'b0;
         ptr_q   <= 1'b0;
         addr_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         addr_q  <= addr_d;
         rdata_q <= rdata_d;
      end
   end

   // Outputs decode registered state only; requests never reach a pin combinationally.
   assign bus.busy_o    = (state_q != ST_IDLE);
   assign bus.gnt0_o    = (state_q != ST_IDLE) && !owner_q;
   assign bus.gnt1_o    = (state_q != ST_IDLE) &&  owner_q;
   assign bus.rvalid0_o = (state_q == ST_DONE) && !owner_q;
   assign bus.rvalid1_o = (state_q == ST_DONE) &&  owner_q;
   assign bus.rdata_o   = rdata_q;

   assign rom_cs_no  = !((state_q == ST_SETUP) || (state_q == ST_READ));
   assign rom_oe_o   = (state_q == ST_READ);
   assign rom_addr_o = addr_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed self-checking bench for rom_arbiter with a behavioural asynchronous ROM.
module tb_rom_arbiter;
   logic       clk = 1'b0;
   logic       rst;
   logic       rom_cs_n;
   logic       rom_oe;
   logic [4:0] rom_addr;
   logic [7:0] rom_data;
   logic [7:0] rom_mem [32];
   int         n_assert = 0;
   int         n_fail   = 0;

   rom_arbiter_if #(.Width(8), .Depth(5)) bus ();

   rom_arbiter #(.Width(8), .Depth(5)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .bus        (bus),
      .rom_cs_no  (rom_cs_n),
      .rom_oe_o   (rom_oe),
      .rom_addr_o (rom_addr),
      .rom_data_i (rom_data)
   );

   always #5 clk = ~clk;

   // Asynchronous-read ROM: drives data only while selected and output-enabled.
   assign rom_data = (!rom_cs_n && rom_oe) ? rom_mem[rom_addr] : 8'hzz;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, " cs_n"},    32'(rom_cs_n),      32'd1);
      check({tag, " oe"},      32'(rom_oe),        32'd0);
      check({tag, " gnt0"},    32'(bus.gnt0_o),    32'd0);
      check({tag, " gnt1"},    32'(bus.gnt1_o),    32'd0);
      check({tag, " rvalid0"}, 32'(bus.rvalid0_o), 32'd0);
      check({tag, " rvalid1"}, 32'(bus.rvalid1_o), 32'd0);
      check({tag, " busy"},    32'(bus.busy_o),    32'd0);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rom_mem[i] = 8'(i * 3);
      rom_mem[5'h04] = 8'h58;
      rom_mem[5'h05] = 8'hED;
      rom_mem[5'h06] = 8'hB7;
      rom_mem[5'h07] = 8'h34;
      rom_mem[5'h08] = 8'hC3;
      rom_mem[5'h0D] = 8'h11;
      rom_mem[5'h18] = 8'hxx;
      rom_mem[5'h1C] = 8'h12;
      rom_mem[5'h1D] = 8'hAF;

      // Reset held two cycles with random requests.
      rst         = 1'b1;
      bus.req0_i  = 1'($urandom_range(0, 1));
      bus.req1_i  = 1'($urandom_range(0, 1));
      bus.addr0_i = 5'($urandom_range(0, 31));
      bus.addr1_i = 5'($urandom_range(0, 31));
      tick();
      tick();
      check_idle("reset");
      check("reset rdata", 32'(bus.rdata_o), 32'h0);
      check("reset addr",  32'(rom_addr),    32'h0);
      rst        = 1'b0;
      bus.req0_i = 1'b0;
      bus.req1_i = 1'b0;
      tick();
      check_idle("post-reset");

      // Single read of 0x04 by client 0.
      bus.req0_i  = 1'b1;
      bus.addr0_i = 5'h04;
      tick();
      check("single setup gnt0", 32'(bus.gnt0_o), 32'd1);
      check("single setup cs_n", 32'(rom_cs_n),   32'd0);
      check("single setup oe",   32'(rom_oe),     32'd0);
      check("single setup addr", 32'(rom_addr),   32'h04);
      check("single setup rv0",  32'(bus.rvalid0_o), 32'd0);
      tick();
      check("single read cs_n",  32'(rom_cs_n),   32'd0);
      check("single read oe",    32'(rom_oe),     32'd1);
      check("single read rv0",   32'(bus.rvalid0_o), 32'd0);
      tick();
      check("single done rv0",   32'(bus.rvalid0_o), 32'd1);
      check("single done rv1",   32'(bus.rvalid1_o), 32'd0);
      check("single done rdata", 32'(bus.rdata_o), 32'h58);
      check("single done cs_n",  32'(rom_cs_n),   32'd1);
      check("single done oe",    32'(rom_oe),     32'd0);
      bus.req0_i = 1'b0;
      tick();
      check_idle("single idle");
      check("single idle addr",  32'(rom_addr),   32'h04);
      check("single idle rdata", 32'(bus.rdata_o), 32'h58);

      // Contention straight after reset: client 0 first, client 1 four cycles later.
      rst = 1'b1;
      tick();
      rst         = 1'b0;
      bus.req0_i  = 1'b1;
      bus.addr0_i = 5'h05;
      bus.req1_i  = 1'b1;
      bus.addr1_i = 5'h06;
      tick();
      check("cont first gnt0", 32'(bus.gnt0_o), 32'd1);
      check("cont first gnt1", 32'(bus.gnt1_o), 32'd0);
      tick();
      tick();
      check("cont rv0",        32'(bus.rvalid0_o), 32'd1);
      check("cont rv1 low",    32'(bus.rvalid1_o), 32'd0);
      check("cont rdata0",     32'(bus.rdata_o),   32'hED);
      bus.req0_i = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         tick();
         check($sformatf("cont rv1 at +%0d", c), 32'(bus.rvalid1_o), 32'(c == 4));
         if (c == 2) begin
            check("cont second gnt1", 32'(bus.gnt1_o), 32'd1);
            check("cont second addr", 32'(rom_addr),   32'h06);
         end
      end
      check("cont rdata1", 32'(bus.rdata_o),   32'hB7);
      check("cont rv0 off", 32'(bus.rvalid0_o), 32'd0);
      bus.req1_i = 1'b0;
      tick();

      // Fairness: both held for four accesses, grants alternate starting with client 0.
      bus.req0_i  = 1'b1;
      bus.addr0_i = 5'h1C;
      bus.req1_i  = 1'b1;
      bus.addr1_i = 5'h1D;
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("fair %0d gnt0", k), 32'(bus.gnt0_o), 32'(k % 2 == 0));
         check($sformatf("fair %0d gnt1", k), 32'(bus.gnt1_o), 32'(k % 2 == 1));
         tick();
         check($sformatf("fair %0d overlap read", k), 32'(bus.rvalid0_o | bus.rvalid1_o), 32'd0);
         tick();
         check($sformatf("fair %0d rv0", k), 32'(bus.rvalid0_o), 32'(k % 2 == 0));
         check($sformatf("fair %0d rv1", k), 32'(bus.rvalid1_o), 32'(k % 2 == 1));
         check($sformatf("fair %0d rdata", k), 32'(bus.rdata_o), (k % 2 == 0) ? 32'h12 : 32'hAF);
         tick();
         check($sformatf("fair %0d idle busy", k), 32'(bus.busy_o), 32'd0);
      end
      bus.req0_i = 1'b0;
      bus.req1_i = 1'b0;
      tick();

      // Address change during SETUP is ignored.
      bus.req0_i  = 1'b1;
      bus.addr0_i = 5'h07;
      tick();
      bus.addr0_i = 5'h08;
      check("robust setup addr", 32'(rom_addr), 32'h07);
      tick();
      check("robust read addr",  32'(rom_addr), 32'h07);
      tick();
      check("robust rv0",   32'(bus.rvalid0_o), 32'd1);
      check("robust rdata", 32'(bus.rdata_o),   32'h34);
      bus.req0_i = 1'b0;
      tick();

      // Unprogrammed location: X bits pass through unmasked.
      bus.req1_i  = 1'b1;
      bus.addr1_i = 5'h18;
      tick();
      tick();
      tick();
      check("x rv1",   32'(bus.rvalid1_o), 32'd1);
      check("x rdata", 32'(bus.rdata_o),   {24'h0, 8'hxx});
      bus.req1_i = 1'b0;
      tick();

      // Reset during READ aborts the access.
      bus.req0_i  = 1'b1;
      bus.addr0_i = 5'h04;
      tick();
      tick();
      check("abort read oe", 32'(rom_oe), 32'd1);
      rst = 1'b1;
      tick();
      check_idle("abort reset");
      check("abort rdata", 32'(bus.rdata_o), 32'h0);
      check("abort addr",  32'(rom_addr),    32'h0);
      rst        = 1'b0;
      bus.req0_i = 1'b0;
      tick();
      check_idle("abort after");
      tick();
      check("abort no late rv0", 32'(bus.rvalid0_o), 32'd0);

      // Fresh request from client 1 after the aborted access.
      bus.req1_i  = 1'b1;
      bus.addr1_i = 5'h0D;
      tick();
      check("resume gnt1", 32'(bus.gnt1_o), 32'd1);
      tick();
      tick();
      check("resume rv1",   32'(bus.rvalid1_o), 32'd1);
      check("resume rv0",   32'(bus.rvalid0_o), 32'd0);
      check("resume rdata", 32'(bus.rdata_o),   32'h11);
      bus.req1_i = 1'b0;
      tick();
      check_idle("resume idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
